// File: rtl/bp_me_accel_scratchpad.sv
// BedRock mem_fwd/mem_rev responder backed by a local scratchpad of 128-bit lines.
// Serves uncached reads and writes one command at a time, one response per command.
module bp_me_accel_scratchpad #(
  parameter int paddr_width_p        = 40,
  parameter int payload_width_p      = 16,
  parameter int bedrock_fill_width_p = 64,
  parameter int els_p                = 64,
  localparam int mem_fwd_header_width_lp = 4 + 4 + paddr_width_p + 3 + payload_width_p,
  localparam int mem_rev_header_width_lp = mem_fwd_header_width_lp
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_i,
  input  logic [63:0]                        mem_fwd_data_i,
  input  logic                               mem_fwd_v_i,
  output logic                               mem_fwd_ready_and_o,
  output logic [mem_rev_header_width_lp-1:0] mem_rev_header_o,
  output logic [63:0]                        mem_rev_data_o,
  output logic                               mem_rev_v_o,
  input  logic                               mem_rev_ready_and_i,
  output logic                               err_o
);

  localparam int lg_els_lp  = $clog2(els_p);
  localparam int idx_top_lp = 4 + lg_els_lp;

  if (bedrock_fill_width_p != 64) begin : g_bad_fill
    $error("bp_me_accel_scratchpad: bedrock_fill_width_p must be 64");
  end
  if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
    $error("bp_me_accel_scratchpad: els_p must be a power of two >= 2");
  end

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } msg_type_e;

  typedef struct packed {
    logic [payload_width_p-1:0] payload;
    logic [2:0]                 size;
    logic [paddr_width_p-1:0]   addr;
    logic [3:0]                 subop;
    logic [3:0]                 msg_type;
  } hdr_s;

  typedef enum logic [1:0] {e_ready, e_recv, e_send} state_e;

  hdr_s                   fwd_hdr, hdr_r;
  state_e                 state_r;
  logic                   beat_r, err_r, ready_r, rev_v_r;
  logic [3:0]             cur_type;
  logic [2:0]             cur_size, size_eff;
  logic [idx_top_lp-1:0]  cur_addr;
  logic [lg_els_lp-1:0]   cur_idx;
  logic [3:0]             nbytes;
  logic                   cur_is_wr, cur_is_rd, cur_line, bad_req;
  logic [7:0]             wr_mask;
  logic [63:0]            rd_word, rd_shift, rd_data;
  logic                   fwd_hs, rev_hs;
  logic [127:0]           mem_r [els_p];

  assign fwd_hdr = mem_fwd_header_i;
  assign fwd_hs  = mem_fwd_v_i & ready_r;
  assign rev_hs  = rev_v_r & mem_rev_ready_and_i;

  // While idle the live header is decoded; afterwards the latched copy drives everything.
  always_comb begin
    cur_type  = (state_r == e_ready) ? fwd_hdr.msg_type : hdr_r.msg_type;
    cur_size  = (state_r == e_ready) ? fwd_hdr.size     : hdr_r.size;
    cur_addr  = (state_r == e_ready) ? fwd_hdr.addr[idx_top_lp-1:0] : hdr_r.addr[idx_top_lp-1:0];
    cur_is_wr = (cur_type == e_bedrock_mem_uc_wr) || (cur_type == e_bedrock_mem_wr);
    cur_is_rd = (cur_type == e_bedrock_mem_uc_rd) || (cur_type == e_bedrock_mem_rd);
    size_eff  = (cur_size > 3'd4) ? 3'd4 : cur_size;
    cur_line  = (size_eff == 3'd4);
    cur_idx   = cur_addr[4 +: lg_els_lp];
    nbytes    = 4'd1 << size_eff;
    bad_req   = !(cur_is_wr || cur_is_rd) || (cur_size > 3'd4)
              || (cur_line && (cur_addr[3:0] != 4'd0));
    wr_mask   = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      wr_mask[b] = (b >= 32'(cur_addr[2:0])) && (b < 32'(cur_addr[2:0]) + 32'(nbytes));
    end
    rd_word  = (cur_line ? beat_r : cur_addr[3]) ? mem_r[cur_idx][127:64] : mem_r[cur_idx][63:0];
    rd_shift = rd_word >> {cur_addr[2:0], 3'b000};
    case (size_eff)
      3'd0:    rd_data = {8{rd_shift[7:0]}};
      3'd1:    rd_data = {4{rd_shift[15:0]}};
      3'd2:    rd_data = {2{rd_shift[31:0]}};
      3'd3:    rd_data = rd_shift;
      default: rd_data = rd_word;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (fwd_hs && cur_is_wr) begin
      if (state_r == e_recv) begin
        mem_r[cur_idx][127:64] <= mem_fwd_data_i;
      end else if (cur_line) begin
        mem_r[cur_idx][63:0] <= mem_fwd_data_i;
      end else begin
        for (int unsigned b = 0; b < 8; b++) begin
          if (wr_mask[b]) mem_r[cur_idx][32'(cur_addr[3]) * 64 + b * 8 +: 8] <= mem_fwd_data_i[b * 8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      hdr_r   <= '0;
      beat_r  <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
      rev_v_r <= 1'b0;
    end else begin
      case (state_r)
        e_ready: if (fwd_hs) begin
          hdr_r  <= fwd_hdr;
          beat_r <= 1'b0;
          if (bad_req) err_r <= 1'b1;
          if (cur_is_wr && cur_line) begin
            state_r <= e_recv;
          end else begin
            state_r <= e_send;
            ready_r <= 1'b0;
            rev_v_r <= 1'b1;
          end
        end
        e_recv: if (fwd_hs) begin
          state_r <= e_send;
          ready_r <= 1'b0;
          rev_v_r <= 1'b1;
        end
        e_send: if (rev_hs) begin
          if (cur_is_rd && cur_line && !beat_r) begin
            beat_r <= 1'b1;
          end else begin
            beat_r  <= 1'b0;
            state_r <= e_ready;
            ready_r <= 1'b1;
            rev_v_r <= 1'b0;
          end
        end
        default: begin
          state_r <= e_ready;
          ready_r <= 1'b1;
          rev_v_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_fwd_ready_and_o = ready_r;
  assign mem_rev_v_o         = rev_v_r;
  assign mem_rev_header_o    = hdr_r;
  assign mem_rev_data_o      = (rev_v_r && cur_is_rd) ? rd_data : '0;
  assign err_o               = err_r;

endmodule

// File: tb/tb_bp_me_accel_scratchpad.sv
// Scoreboard bench for bp_me_accel_scratchpad: a byte-array model predicts every rev beat.
module tb_bp_me_accel_scratchpad;

  localparam int PADDR     = 40;
  localparam int PAYLOAD   = 16;
  localparam int HDR_W     = 4 + 4 + PADDR + 3 + PAYLOAD;
  localparam int ELS       = 64;
  localparam int MDL_BYTES = ELS * 16;
  localparam int MDL_LG    = $clog2(MDL_BYTES);

  localparam logic [3:0] T_RD = 4'd0, T_WR = 4'd1, T_UCRD = 4'd2, T_UCWR = 4'd3, T_PRE = 4'd4;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic [HDR_W-1:0] fwd_hdr = '0;
  logic [63:0]      fwd_data = '0;
  logic             fwd_v = 1'b0;
  logic             fwd_ready;
  logic [HDR_W-1:0] rev_hdr;
  logic [63:0]      rev_data;
  logic             rev_v;
  logic             rev_ready = 1'b0;
  logic             err;

  always #5 clk_i = ~clk_i;

  bp_me_accel_scratchpad #(
    .paddr_width_p(PADDR),
    .payload_width_p(PAYLOAD),
    .bedrock_fill_width_p(64),
    .els_p(ELS)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .mem_fwd_header_i(fwd_hdr),
    .mem_fwd_data_i(fwd_data),
    .mem_fwd_v_i(fwd_v),
    .mem_fwd_ready_and_o(fwd_ready),
    .mem_rev_header_o(rev_hdr),
    .mem_rev_data_o(rev_data),
    .mem_rev_v_o(rev_v),
    .mem_rev_ready_and_i(rev_ready),
    .err_o(err)
  );

  typedef struct {
    logic [HDR_W-1:0] hdr;
    logic [63:0]      data;
    string            name;
  } exp_t;

  exp_t        sb[$];
  int          nchk = 0;
  int          nerr = 0;
  logic [7:0]  mdl [MDL_BYTES];

  function automatic logic [HDR_W-1:0] mk_hdr(logic [3:0] t, logic [2:0] sz, logic [PADDR-1:0] a);
    return {PAYLOAD'({a[11:4], 8'h5A}), sz, a, 4'h0, t};
  endfunction

  function automatic logic [63:0] mdl_line(logic [PADDR-1:0] a, int k);
    int base;
    logic [63:0] r;
    base = int'(a[MDL_LG-1:0]);
    base = base - (base % 16);
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = mdl[base + 8*k + i];
    return r;
  endfunction

  function automatic logic [63:0] mdl_narrow(logic [PADDR-1:0] a, logic [2:0] sz);
    int base, n;
    logic [63:0] r;
    base = int'(a[MDL_LG-1:0]);
    n = 1 << sz;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = mdl[(base + (j % n)) % MDL_BYTES];
    return r;
  endfunction

  function automatic void mdl_write(logic [PADDR-1:0] a, logic [2:0] sz, logic [63:0] d0, logic [63:0] d1);
    int base, n;
    base = int'(a[MDL_LG-1:0]);
    if (sz == 3'd4) begin
      base = base - (base % 16);
      for (int i = 0; i < 8; i++) begin
        mdl[base + i]     = d0[i*8 +: 8];
        mdl[base + 8 + i] = d1[i*8 +: 8];
      end
    end else begin
      n = 1 << sz;
      for (int i = 0; i < n; i++) mdl[(base + i) % MDL_BYTES] = d0[((base + i) % 8)*8 +: 8];
    end
  endfunction

  task automatic fwd_beat(input logic [HDR_W-1:0] h, input logic [63:0] d);
    int cyc = 0;
    @(negedge clk_i);
    fwd_hdr = h; fwd_data = d; fwd_v = 1'b1;
    while (!fwd_ready && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    if (!fwd_ready) begin
      nchk++; nerr++;
      $display("FAIL fwd_timeout: ready_and stayed %b, required 1", fwd_ready);
      fwd_v = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1 fwd_v = 1'b0;
  endtask

  task automatic get_rev();
    exp_t e;
    int cyc = 0;
    if (sb.size() == 0) begin
      nchk++; nerr++;
      $display("FAIL scoreboard_empty: got 0 entries, required >= 1");
      return;
    end
    e = sb.pop_front();
    @(negedge clk_i);
    rev_ready = 1'b1;
    while (!rev_v && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    nchk++;
    if (!rev_v) begin
      nerr++;
      $display("FAIL %s timeout: rev_v=%b, required 1", e.name, rev_v);
      rev_ready = 1'b0;
      return;
    end
    if (rev_hdr !== e.hdr || rev_data !== e.data) begin
      nerr++;
      $display("FAIL %s: got hdr=%h data=%h, required hdr=%h data=%h", e.name, rev_hdr, rev_data, e.hdr, e.data);
    end
    @(posedge clk_i);
    #1 rev_ready = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] t, input logic [2:0] sz, input logic [PADDR-1:0] a,
                          input string name);
    logic [HDR_W-1:0] h;
    h = mk_hdr(t, sz, a);
    if (t == T_RD || t == T_UCRD) begin
      if (sz == 3'd4) begin
        sb.push_back('{h, mdl_line(a, 0), {name, "_b0"}});
        sb.push_back('{h, mdl_line(a, 1), {name, "_b1"}});
      end else begin
        sb.push_back('{h, mdl_narrow(a, sz), name});
      end
    end else begin
      sb.push_back('{h, 64'h0, name});
    end
  endtask

  task automatic cmd(input logic [3:0] t, input logic [2:0] sz, input logic [PADDR-1:0] a,
                     input logic [63:0] d0, input logic [63:0] d1, input string name);
    logic [HDR_W-1:0] h;
    h = mk_hdr(t, sz, a);
    push_exp(t, sz, a, name);
    if (t == T_WR || t == T_UCWR) mdl_write(a, sz, d0, d1);
    fwd_beat(h, d0);
    if ((t == T_WR || t == T_UCWR) && sz == 3'd4) fwd_beat(h, d1);
    while (sb.size() > 0) get_rev();
  endtask

  task automatic test_reset();
    #12;
    nchk++;
    if (rev_v !== 1'b0 || rev_hdr !== '0 || rev_data !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got v=%b hdr=%h data=%h, required all 0", rev_v, rev_hdr, rev_data);
    end
    nchk++;
    if (err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b, required 0", err); end
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    nchk++;
    if (fwd_ready !== 1'b1 || rev_v !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle: got ready=%b v=%b, required ready=1 v=0", fwd_ready, rev_v);
    end
  endtask

  task automatic test_line_rw();
    cmd(T_UCWR, 3'd4, 40'h100, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, "line_wr_ack");
    cmd(T_UCRD, 3'd4, 40'h100, '0, '0, "line_rd");
  endtask

  task automatic test_narrow();
    cmd(T_UCWR, 3'd0, 40'h10B, {8{8'hAB}}, '0, "byte_wr_ack");
    cmd(T_UCRD, 3'd3, 40'h108, '0, '0, "word_rd_after_byte");
    cmd(T_UCRD, 3'd0, 40'h10B, '0, '0, "byte_rd_repl");
    cmd(T_UCRD, 3'd1, 40'h102, '0, '0, "half_rd_repl");
  endtask

  task automatic test_latency();
    logic [HDR_W-1:0] h;
    h = mk_hdr(T_UCWR, 3'd2, 40'h104);
    push_exp(T_UCWR, 3'd2, 40'h104, "lat_wr_ack");
    mdl_write(40'h104, 3'd2, {2{32'hCAFE_F00D}}, '0);
    fwd_beat(h, {2{32'hCAFE_F00D}});
    nchk++;
    if (rev_v !== 1'b1 || fwd_ready !== 1'b0) begin
      nerr++;
      $display("FAIL rev_latency: got v=%b ready=%b, required v=1 ready=0", rev_v, fwd_ready);
    end
    get_rev();
    nchk++;
    if (fwd_ready !== 1'b1 || rev_v !== 1'b0) begin
      nerr++;
      $display("FAIL fwd_reopen: got ready=%b v=%b, required ready=1 v=0", fwd_ready, rev_v);
    end
  endtask

  task automatic test_backpressure();
    logic [HDR_W-1:0] h;
    h = mk_hdr(T_UCRD, 3'd4, 40'h100);
    push_exp(T_UCRD, 3'd4, 40'h100, "bp_rd");
    fwd_beat(h, 64'hDEAD_BEEF_DEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      nchk++;
      if (rev_v !== 1'b1 || rev_hdr !== sb[0].hdr || rev_data !== sb[0].data || fwd_ready !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold cyc%0d: got v=%b ready=%b hdr=%h data=%h, required v=1 ready=0 hdr=%h data=%h",
                 i, rev_v, fwd_ready, rev_hdr, rev_data, sb[0].hdr, sb[0].data);
      end
    end
    get_rev();
    get_rev();
  endtask

  task automatic test_gap();
    logic [HDR_W-1:0] h;
    h = mk_hdr(T_UCWR, 3'd4, 40'h180);
    push_exp(T_UCWR, 3'd4, 40'h180, "gap_wr_ack");
    mdl_write(40'h180, 3'd4, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    fwd_beat(h, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      nchk++;
      if (rev_v !== 1'b0 || fwd_ready !== 1'b1) begin
        nerr++;
        $display("FAIL gap_wait cyc%0d: got v=%b ready=%b, required v=0 ready=1", i, rev_v, fwd_ready);
      end
    end
    fwd_beat(h, 64'hFEDC_BA98_7654_3210);
    get_rev();
    cmd(T_UCRD, 3'd4, 40'h180, '0, '0, "gap_rd");
  endtask

  task automatic test_alias();
    cmd(T_WR, 3'd4, 40'h400, 64'hA5A5_0000_1234_5678, 64'h5A5A_FFFF_8765_4321, "alias_wr_ack");
    cmd(T_RD, 3'd4, 40'h000, '0, '0, "alias_rd");
  endtask

  task automatic test_random();
    logic [63:0] v, d;
    logic [2:0]  sz;
    int          n, off;
    cmd(T_UCWR, 3'd4, 40'h300, {$urandom, $urandom}, {$urandom, $urandom}, "rand_init");
    for (int it = 0; it < 12; it++) begin
      sz  = 3'($urandom_range(0, 3));
      n   = 1 << sz;
      off = int'($urandom_range(0, 15));
      off = off - (off % n);
      if ($urandom_range(0, 1) == 0) begin
        v = {$urandom, $urandom};
        for (int j = 0; j < 8; j++) d[j*8 +: 8] = v[(j % n)*8 +: 8];
        cmd(T_UCWR, sz, 40'h300 + 40'(off), d, '0, "rand_wr_ack");
      end else begin
        cmd(T_UCRD, sz, 40'h300 + 40'(off), '0, '0, "rand_rd");
      end
    end
    cmd(T_UCRD, 3'd4, 40'h300, '0, '0, "rand_final");
  endtask

  task automatic test_err();
    nchk++;
    if (err !== 1'b0) begin nerr++; $display("FAIL err_pre_clear: got %b, required 0", err); end
    cmd(T_PRE, 3'd3, 40'h20, 64'h1234, '0, "pre_ack");
    nchk++;
    if (err !== 1'b1) begin nerr++; $display("FAIL err_set: got %b, required 1", err); end
    cmd(T_UCRD, 3'd3, 40'h100, '0, '0, "rd_after_err");
    nchk++;
    if (err !== 1'b1) begin nerr++; $display("FAIL err_sticky: got %b, required 1", err); end
  endtask

  task automatic test_reset_mid();
    fwd_beat(mk_hdr(T_UCWR, 3'd4, 40'h200), 64'h7777_7777_7777_7777);
    @(negedge clk_i);
    nchk++;
    if (rev_v !== 1'b0) begin nerr++; $display("FAIL mid_recv: got v=%b, required 0", rev_v); end
    #2 reset_i = 1'b1;
    #1;
    nchk++;
    if (fwd_ready !== 1'b1 || rev_v !== 1'b0 || err !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset: got ready=%b v=%b err=%b, required ready=1 v=0 err=0", fwd_ready, rev_v, err);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      nchk++;
      if (rev_v !== 1'b0) begin nerr++; $display("FAIL dropped_msg cyc%0d: got v=%b, required 0", i, rev_v); end
    end
    cmd(T_UCRD, 3'd4, 40'h100, '0, '0, "rd_after_reset");
  endtask

  initial begin
    test_reset();
    test_line_rw();
    test_narrow();
    test_latency();
    test_backpressure();
    test_gap();
    test_alias();
    test_random();
    test_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
